// File: rtl/alu_operand_stage_pkg.sv
// Shared widths, ALUOp encodings and the immediate-extension helper
// for the operand-fetch stage that feeds the 32-bit ALU.
package alu_operand_stage_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_N      = 32;
  localparam int REG_ADDR_W = $clog2(REG_N);
  localparam int OP_W       = 3;
  localparam int IMM_W      = 16;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

  typedef enum logic [OP_W-1:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SRL = 3'b100,
    ALU_SRA = 3'b101
  } alu_op_e;

  function automatic logic [DATA_W-1:0] extendImm(input logic [IMM_W-1:0] imm,
                                                  input logic              signExt);
    return signExt ? {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm}
                   : {{(DATA_W-IMM_W){1'b0}}, imm};
  endfunction

endpackage

// File: rtl/alu_operand_stage_if.sv
// Instruction-in / operands-out / writeback bundle of the operand stage.
// The stage itself uses the slave view; whatever drives it uses master.
interface alu_operand_stage_if;
  import alu_operand_stage_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [REG_ADDR_W-1:0] rs;
  logic [REG_ADDR_W-1:0] rt;
  logic [REG_ADDR_W-1:0] rd_in;
  logic [IMM_W-1:0]      imm16;
  logic                  use_imm;
  logic                  ext_sign;
  logic [OP_W-1:0]       alu_op_in;
  logic                  wb_en;
  logic [REG_ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0]     wb_data;
  logic                  flush;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_W-1:0]     A;
  logic [DATA_W-1:0]     B;
  logic [OP_W-1:0]       ALUOp;
  logic [REG_ADDR_W-1:0] rd_out;

  modport master (
    output in_valid, rs, rt, rd_in, imm16, use_imm, ext_sign, alu_op_in,
           wb_en, wb_addr, wb_data, flush, out_ready,
    input  in_ready, out_valid, A, B, ALUOp, rd_out
  );

  modport slave (
    input  in_valid, rs, rt, rd_in, imm16, use_imm, ext_sign, alu_op_in,
           wb_en, wb_addr, wb_data, flush, out_ready,
    output in_ready, out_valid, A, B, ALUOp, rd_out
  );

endinterface

// File: rtl/alu_operand_stage_grf.sv
// 32x32 general register file: one write port, two combinational read ports
// with write-first bypass; register 0 is hard-wired to zero.
module alu_operand_stage_grf
  import alu_operand_stage_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wb_en_i,
  input  logic [REG_ADDR_W-1:0] wb_addr_i,
  input  logic [DATA_W-1:0]     wb_data_i,
  input  logic [REG_ADDR_W-1:0] rs_addr_i,
  input  logic [REG_ADDR_W-1:0] rt_addr_i,
  output logic [DATA_W-1:0]     rs_data_o,
  output logic [DATA_W-1:0]     rt_data_o
);

  logic [DATA_W-1:0] regs_q [REG_N];
  logic              wrActive;

  assign wrActive = wb_en_i && (wb_addr_i != ZERO_REG);

  // Entry 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_N; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wrActive) begin
      regs_q[wb_addr_i] <= wb_data_i;
    end
  end

  assign rs_data_o = (wrActive && wb_addr_i == rs_addr_i) ? wb_data_i : regs_q[rs_addr_i];
  assign rt_data_o = (wrActive && wb_addr_i == rt_addr_i) ? wb_data_i : regs_q[rt_addr_i];

endmodule

// File: rtl/alu_operand_stage.sv
// Operand-fetch stage: reads the GRF, forms A/B, and holds them in a single
// valid/ready pipeline register (with flush) in front of the ALU.
module alu_operand_stage
  import alu_operand_stage_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  alu_operand_stage_if.slave  bus
);

  logic [DATA_W-1:0]     rsData;
  logic [DATA_W-1:0]     rtData;
  logic [DATA_W-1:0]     immExt;
  logic [DATA_W-1:0]     opBNext;
  logic                  inReady;
  logic                  accept;

  logic                  valid_q, valid_d;
  logic [DATA_W-1:0]     opA_q, opA_d;
  logic [DATA_W-1:0]     opB_q, opB_d;
  logic [OP_W-1:0]       aluOp_q, aluOp_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;

  alu_operand_stage_grf u_grf (
    .clk       (clk),
    .rst_n     (rst_n),
    .wb_en_i   (bus.wb_en),
    .wb_addr_i (bus.wb_addr),
    .wb_data_i (bus.wb_data),
    .rs_addr_i (bus.rs),
    .rt_addr_i (bus.rt),
    .rs_data_o (rsData),
    .rt_data_o (rtData)
  );

  assign immExt  = extendImm(bus.imm16, bus.ext_sign);
  assign opBNext = bus.use_imm ? immExt : rtData;

  assign inReady = !valid_q || bus.out_ready;
  assign accept  = bus.in_valid && inReady && !bus.flush;

  // Flush is applied last so it overrides both a new accept and a held payload.
  always_comb begin
    valid_d = valid_q && !bus.out_ready;
    opA_d   = opA_q;
    opB_d   = opB_q;
    aluOp_d = aluOp_q;
    rd_d    = rd_q;
    if (accept) begin
      valid_d = 1'b1;
      opA_d   = rsData;
      opB_d   = opBNext;
      aluOp_d = bus.alu_op_in;
      rd_d    = bus.rd_in;
    end
    if (bus.flush) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      opA_q   <= '0;
      opB_q   <= '0;
      aluOp_q <= '0;
      rd_q    <= '0;
    end else begin
      valid_q <= valid_d;
      opA_q   <= opA_d;
      opB_q   <= opB_d;
      aluOp_q <= aluOp_d;
      rd_q    <= rd_d;
    end
  end

  assign bus.in_ready  = inReady;
  assign bus.out_valid = valid_q;
  assign bus.A         = opA_q;
  assign bus.B         = opB_q;
  assign bus.ALUOp     = aluOp_q;
  assign bus.rd_out    = rd_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: fixed vectors, directed stall/flush/reset
// sequences and random traffic against an instruction-level reference model.
module tb_alu_operand_stage;
  import alu_operand_stage_pkg::*;

  typedef struct {
    logic        inValid;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic        useImm, extSign;
    logic [2:0]  op;
    logic        wbEn;
    logic [4:0]  wbAddr;
    logic [31:0] wbData;
    logic        flush, outReady;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic        expValid;
    logic [31:0] expA, expB;
    logic [2:0]  expOp;
    logic [4:0]  expRd;
  } vec_t;

  logic clk;
  logic rst_n;
  int   testsRun;
  int   testsFailed;

  logic [31:0] mRegs [32];
  logic        mValid;
  logic [31:0] mA, mB;
  logic [2:0]  mOp;
  logic [4:0]  mRd;

  alu_operand_stage_if bus ();

  alu_operand_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t mkStim(input logic iv, input logic [4:0] rs, input logic [4:0] rt,
                                   input logic [4:0] rd, input logic [15:0] imm, input logic ui,
                                   input logic es, input logic [2:0] op, input logic we,
                                   input logic [4:0] wa, input logic [31:0] wd, input logic fl,
                                   input logic ro);
    stim_t s;
    s.inValid = iv; s.rs = rs; s.rt = rt; s.rd = rd; s.imm = imm; s.useImm = ui;
    s.extSign = es; s.op = op; s.wbEn = we; s.wbAddr = wa; s.wbData = wd;
    s.flush = fl; s.outReady = ro;
    return s;
  endfunction

  task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string name, input logic eValid, input logic [31:0] eA,
                             input logic [31:0] eB, input logic [2:0] eOp, input logic [4:0] eRd);
    checkEq({name, " out_valid"}, {31'b0, bus.out_valid}, {31'b0, eValid});
    if (eValid) begin
      checkEq({name, " A"}, bus.A, eA);
      checkEq({name, " B"}, bus.B, eB);
      checkEq({name, " ALUOp"}, {29'b0, bus.ALUOp}, {29'b0, eOp});
      checkEq({name, " rd_out"}, {27'b0, bus.rd_out}, {27'b0, eRd});
    end
  endtask

  task automatic checkModel(input string name);
    checkOutput(name, mValid, mA, mB, mOp, mRd);
  endtask

  task automatic modelReset();
    for (int i = 0; i < 32; i++) mRegs[i] = '0;
    mValid = 1'b0; mA = '0; mB = '0; mOp = '0; mRd = '0;
  endtask

  // Register value as seen by an instruction issued in the same cycle as s's writeback.
  function automatic logic [31:0] readReg(input logic [4:0] a, input stim_t s);
    if (a == 5'd0) return 32'd0;
    if (s.wbEn && s.wbAddr == a) return s.wbData;
    return mRegs[a];
  endfunction

  task automatic modelStep(input stim_t s);
    logic [31:0] immVal;
    logic        ready;
    immVal = s.extSign ? 32'($signed(s.imm)) : 32'(s.imm);
    ready  = !mValid || s.outReady;
    if (s.flush) begin
      mValid = 1'b0;
    end else if (s.inValid && ready) begin
      mValid = 1'b1;
      mA     = readReg(s.rs, s);
      mB     = s.useImm ? immVal : readReg(s.rt, s);
      mOp    = s.op;
      mRd    = s.rd;
    end else if (s.outReady) begin
      mValid = 1'b0;
    end
    if (s.wbEn && s.wbAddr != 5'd0) mRegs[s.wbAddr] = s.wbData;
  endtask

  task automatic driveStim(input stim_t s);
    bus.in_valid  = s.inValid;  bus.rs       = s.rs;      bus.rt        = s.rt;
    bus.rd_in     = s.rd;       bus.imm16    = s.imm;     bus.use_imm   = s.useImm;
    bus.ext_sign  = s.extSign;  bus.alu_op_in = s.op;     bus.wb_en     = s.wbEn;
    bus.wb_addr   = s.wbAddr;   bus.wb_data  = s.wbData;  bus.flush     = s.flush;
    bus.out_ready = s.outReady;
  endtask

  // Drive one cycle of inputs, check in_ready, advance model and DUT by one edge.
  task automatic applyStimulus(input stim_t s);
    driveStim(s);
    #1;
    checkEq("in_ready", {31'b0, bus.in_ready}, {31'b0, (!mValid || s.outReady)});
    modelStep(s);
    @(posedge clk);
    #1;
  endtask

  vec_t        vecs [10];
  stim_t       s;
  stim_t       idle;
  logic [31:0] hA, hB;
  logic [2:0]  hOp;
  logic [4:0]  hRd;

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    idle = mkStim(0, 0, 0, 0, 16'h0, 0, 0, 3'd0, 0, 0, 32'h0, 0, 1);

    vecs[0] = '{mkStim(0, 0, 0, 0, 16'h0,    0, 0, ALU_ADD, 1, 5, 32'h1234_5678, 0, 1), 0, 32'h0, 32'h0, 3'd0, 5'd0};
    vecs[1] = '{mkStim(1, 5, 0, 1, 16'h0,    0, 0, ALU_ADD, 0, 0, 32'h0,         0, 1), 1, 32'h1234_5678, 32'h0, 3'b000, 5'd1};
    vecs[2] = '{mkStim(1, 7, 5, 2, 16'h0,    0, 0, ALU_SUB, 1, 7, 32'hDEAD_BEEF, 0, 1), 1, 32'hDEAD_BEEF, 32'h1234_5678, 3'b001, 5'd2};
    vecs[3] = '{mkStim(1, 0, 7, 3, 16'h0,    0, 0, ALU_AND, 1, 0, 32'hFFFF_FFFF, 0, 1), 1, 32'h0, 32'hDEAD_BEEF, 3'b010, 5'd3};
    vecs[4] = '{mkStim(1, 0, 7, 4, 16'h8001, 1, 1, ALU_OR,  0, 0, 32'h0,         0, 1), 1, 32'h0, 32'hFFFF_8001, 3'b011, 5'd4};
    vecs[5] = '{mkStim(1, 0, 0, 5, 16'h8001, 1, 0, ALU_SRL, 0, 0, 32'h0,         0, 1), 1, 32'h0, 32'h0000_8001, 3'b100, 5'd5};
    vecs[6] = '{mkStim(1, 5, 9, 6, 16'h0,    0, 0, ALU_SRA, 1, 9, 32'hA5A5_0F0F, 0, 1), 1, 32'h1234_5678, 32'hA5A5_0F0F, 3'b101, 5'd6};
    vecs[7] = '{mkStim(1, 9, 0, 7, 16'h7FFF, 1, 1, ALU_ADD, 0, 0, 32'h0,         0, 1), 1, 32'hA5A5_0F0F, 32'h0000_7FFF, 3'b000, 5'd7};
    vecs[8] = '{mkStim(0, 0, 0, 0, 16'h0,    0, 0, ALU_ADD, 0, 0, 32'h0,         0, 1), 0, 32'h0, 32'h0, 3'd0, 5'd0};
    vecs[9] = '{mkStim(1, 0, 0, 8, 16'h0,    0, 0, ALU_ADD, 0, 0, 32'h0,         0, 1), 1, 32'h0, 32'h0, 3'b000, 5'd8};

    // Power-on reset
    rst_n = 1'b0;
    driveStim(idle);
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset", 0, 32'h0, 32'h0, 3'd0, 5'd0);
    checkEq("reset A", bus.A, 32'h0);
    checkEq("reset B", bus.B, 32'h0);
    checkEq("reset ALUOp", {29'b0, bus.ALUOp}, 32'h0);
    checkEq("reset rd_out", {27'b0, bus.rd_out}, 32'h0);
    #3 rst_n = 1'b1;

    // Fixed vectors: write, bypass, zero register, immediate extension
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].s);
      checkOutput($sformatf("vec%0d", i), vecs[i].expValid, vecs[i].expA, vecs[i].expB,
                  vecs[i].expOp, vecs[i].expRd);
    end

    // Back-pressure: hold X while Y waits, with a write to a held source register
    applyStimulus(mkStim(1, 5, 9, 10, 16'h0, 0, 0, ALU_OR, 0, 0, 32'h0, 0, 1));
    checkOutput("bp load", 1, 32'h1234_5678, 32'hA5A5_0F0F, 3'b011, 5'd10);
    hA = bus.A; hB = bus.B; hOp = bus.ALUOp; hRd = bus.rd_out;
    for (int k = 0; k < 3; k++) begin
      s = mkStim(1, 9, 5, 11, 16'h0, 0, 0, ALU_SUB, (k == 1), 5, 32'h5555_5555, 0, 0);
      applyStimulus(s);
      checkEq($sformatf("bp%0d in_ready", k), {31'b0, bus.in_ready}, 32'h0);
      checkOutput($sformatf("bp hold%0d", k), 1, 32'h1234_5678, 32'hA5A5_0F0F, 3'b011, 5'd10);
    end
    applyStimulus(mkStim(1, 9, 5, 11, 16'h0, 0, 0, ALU_SUB, 0, 0, 32'h0, 0, 1));
    checkOutput("bp release", 1, 32'hA5A5_0F0F, 32'h5555_5555, 3'b001, 5'd11);

    // Ten back-to-back instructions with no bubbles
    for (int k = 0; k < 10; k++) begin
      s = mkStim(1, 5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)), 5'(k + 12),
                 16'($urandom), 1'($urandom), 1'($urandom), 3'($urandom_range(0, 5)),
                 1'($urandom), 5'($urandom_range(0, 15)), $urandom, 0, 1);
      applyStimulus(s);
      checkEq($sformatf("b2b%0d out_valid", k), {31'b0, bus.out_valid}, 32'h1);
      checkModel($sformatf("b2b%0d", k));
    end

    // Flush while holding and offering: both die, the same-cycle write survives
    applyStimulus(mkStim(1, 9, 9, 31, 16'h0, 0, 0, ALU_AND, 1, 12, 32'hCAFE_F00D, 1, 0));
    checkOutput("flush", 0, 32'h0, 32'h0, 3'd0, 5'd0);
    applyStimulus(idle);
    checkOutput("flush after", 0, 32'h0, 32'h0, 3'd0, 5'd0);
    applyStimulus(mkStim(1, 12, 0, 13, 16'h0, 0, 0, ALU_ADD, 0, 0, 32'h0, 0, 1));
    checkOutput("flush wb", 1, 32'hCAFE_F00D, 32'h0, 3'b000, 5'd13);

    // Asynchronous reset in the middle of a stall
    applyStimulus(mkStim(1, 5, 9, 14, 16'h0, 0, 0, ALU_SRA, 0, 0, 32'h0, 0, 0));
    checkOutput("pre-reset hold", 1, 32'hCAFE_F00D, 32'h0, 3'b000, 5'd13);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async reset", 0, 32'h0, 32'h0, 3'd0, 5'd0);
    checkEq("async reset A", bus.A, 32'h0);
    checkEq("async reset B", bus.B, 32'h0);
    checkEq("async reset ALUOp", {29'b0, bus.ALUOp}, 32'h0);
    driveStim(idle);
    modelReset();
    @(posedge clk);
    #3 rst_n = 1'b1;
    applyStimulus(mkStim(1, 5, 9, 15, 16'h0, 0, 0, ALU_ADD, 0, 0, 32'h0, 0, 1));
    checkOutput("post-reset read", 1, 32'h0, 32'h0, 3'b000, 5'd15);

    // Random traffic against the reference model
    for (int k = 0; k < 400; k++) begin
      s = mkStim(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 5'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 3'($urandom_range(0, 5)),
                 1'($urandom), 5'($urandom_range(0, 7)), $urandom,
                 ($urandom_range(0, 15) == 0), ($urandom_range(0, 9) < 7));
      applyStimulus(s);
      checkModel($sformatf("rand%0d", k));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Operand-fetch stage directly upstream of the 32-bit ALU. It produces the ALU's A, B and ALUOp inputs.
- Contains the 32x32 general register file (GRF) with write-first bypass, immediate extension and B-operand select.
- A single pipeline register with a valid/ready handshake, stall and flush sits between the register file and the ALU.
- Writeback from later stages enters through the wb_* port.

Parameters:
- DATA_W, 32, register/operand width
- REG_N, 32, number of GRF entries (address width = log2(REG_N) = 5)
- OP_W, 3, ALUOp width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream offers an instruction this cycle
- in_ready  out  1  stage accepts this cycle
- rs  in  5  A-operand register index
- rt  in  5  B-operand register index
- rd_in  in  5  destination index, passed through
- imm16  in  16  immediate field
- use_imm  in  1  1: B = extended imm16; 0: B = GRF[rt]
- ext_sign  in  1  1: sign-extend imm16; 0: zero-extend
- alu_op_in  in  3  operation code, passed through
- wb_en  in  1  writeback enable
- wb_addr  in  5  writeback index
- wb_data  in  32  writeback value
- flush  in  1  kill the held and incoming instruction
- out_valid  out  1  A/B/ALUOp/rd_out are valid
- out_ready  in  1  downstream consumes this cycle
- A  out  32  ALU operand A
- B  out  32  ALU operand B
- ALUOp  out  3  ALU operation code
- rd_out  out  5  destination index

Behaviour:
- Reset:
  - Reset is asynchronous and active-low: while rst_n=0, every GRF entry = 0, out_valid = 0, A = B = 0, ALUOp = 0, rd_out = 0.
  - Deassertion takes effect at the next clk edge.
  - Reset mid-transfer drops the held instruction; there is no replay.
- GRF write:
  - On posedge, if wb_en && wb_addr != 0, then GRF[wb_addr] <= wb_data.
  - Writes to index 0 are ignored; GRF[0] always reads 0.
- GRF read:
  - Two combinational read ports.
  - Bypass: if wb_en && wb_addr == rs && rs != 0, rs_data = wb_data, else GRF[rs]. The rt port uses the same rule.
- Operand formation (combinational, pre-register):
  - A_next = rs_data.
  - Immediate: ext = ext_sign ? {{16{imm16[15]}}, imm16} : {16'b0, imm16}.
  - B_next = use_imm ? ext : rt_data.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational; does not depend on in_valid).
  - accept = in_valid && in_ready && !flush.
  - On accept, A/B/ALUOp/rd_out are loaded from the *_next/alu_op_in/rd_in values.
  - out_valid_next = flush ? 0 : (accept ? 1 : (out_valid && !out_ready)).
  - Simultaneous consume and accept loads the new payload (full throughput, 1 instruction per cycle).
- Latency: one cycle from accept to out_valid=1.
- Stall: while out_valid && !out_ready, the payload is frozen. Later GRF writes to rs/rt do NOT update a held payload; the hazard unit upstream guarantees this never matters.
- Flush:
  - Has priority over everything except reset.
  - Next cycle out_valid = 0. The incoming instruction is not accepted, even when in_ready=1.
  - GRF writes in the same cycle still occur.
  - Payload registers may keep stale data when out_valid=0; the bench checks them only when out_valid=1.
- Widths: no arithmetic in this block beyond extension; all paths are exact-width and no truncation is permitted.

Decomposition:
- Shared package:
  - ALUOp encodings: ADD=3'b000, SUB=3'b001, AND=3'b010, OR=3'b011, SRL=3'b100, SRA=3'b101.
  - DATA_W, REG_ADDR_W=5, ZERO_REG=5'd0.
- One sub-module: grf. Holds the storage array, the write port, the two bypassed read ports and asynchronous reset of all entries.
- Top-level contents: extension, B mux, pipeline register and handshake.

Test Plan:
1. Reset then write: pulse rst_n low, then wb_en=1, wb_addr=5, wb_data=32'h1234_5678. Next cycle issue rs=5, rt=0, use_imm=0, alu_op_in=3'b000 -> one cycle later out_valid=1, A=32'h1234_5678, B=0, ALUOp=000.
2. Bypass plus zero-register write:
   - Same cycle: wb_en=1, wb_addr=7, wb_data=32'hDEAD_BEEF, and issue rs=7 -> A=32'hDEAD_BEEF.
   - Then write wb_addr=0, data=32'hFFFF_FFFF, and issue rs=0 -> A=0.
3. Immediate extension:
   - imm16=16'h8001, use_imm=1, ext_sign=1 -> B=32'hFFFF_8001.
   - Same with ext_sign=0 -> B=32'h0000_8001.
4. Back-pressure:
   - Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, payload stable, exactly one instruction held.
   - Raise out_ready -> next instruction loads the same cycle.
   - Over 10 back-to-back instructions with out_ready=1, out_valid stays 1 with no bubbles.
5. Flush: flush=1 while out_valid=1 and in_valid=1 -> next cycle out_valid=0, and the incoming instruction never appears at the output.
6. Reset mid-stall: out_valid=1, out_ready=0, assert rst_n=0 asynchronously between edges -> out_valid, A, B, ALUOp drop to 0 immediately, and a GRF read of reg 5 returns 0 after release.
